// File: rtl/ok_wirein_sched_pkg.sv
// ok_wirein_sched_pkg: shared widths, FSM state enum, command record and address-window helper for the Wire In sequencer
package ok_wirein_sched_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {IDLE, XFER, UPDATE, GAP} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
  } cmd_t;
  function automatic logic in_range(input logic [ADDR_W-1:0] a, lo, hi);
    return ADDR_W'(a - lo) <= ADDR_W'(hi - lo);
  endfunction
endpackage

// File: rtl/ok_wirein_sched_if.sv
// ok_wirein_sched_if: requester handshakes (req0/req1 valid/ready/addr/data/last) and ti_* Wire In bus; master = host side, slave = sequencer
interface ok_wirein_sched_if;
  import ok_wirein_sched_pkg::*;
  logic              req0_valid, req0_ready, req0_last;
  logic              req1_valid, req1_ready, req1_last;
  logic [ADDR_W-1:0] req0_addr, req1_addr, ti_addr;
  logic [DATA_W-1:0] req0_data, req1_data, ti_datain;
  logic              ti_write, ti_wireupdate;
  modport master (
    output req0_valid, req0_addr, req0_data, req0_last,
    output req1_valid, req1_addr, req1_data, req1_last,
    input  req0_ready, req1_ready, ti_write, ti_addr, ti_datain, ti_wireupdate
  );
  modport slave (
    input  req0_valid, req0_addr, req0_data, req0_last,
    input  req1_valid, req1_addr, req1_data, req1_last,
    output req0_ready, req1_ready, ti_write, ti_addr, ti_datain, ti_wireupdate
  );
endinterface

// File: rtl/ok_rr_arb2.sv
// ok_rr_arb2: 2-way round-robin arbiter (clk, rst, req[1:0], take latches owner, done flips priority away from owner; any, owner out)
module ok_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  input  logic       done,
  output logic       any,
  output logic       owner
);
  logic ptr, pick;
  assign any  = |req;
  assign pick = &req ? ptr : req[1];
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= 1'b0;
      owner <= 1'b0;
    end else begin
      if (take) owner <= pick;
      if (done) ptr <= ~owner;
    end
  end
endmodule

// File: rtl/ok_wirein_sched.sv
// ok_wirein_sched: batches req0/req1 Wire In writes onto ti_* then one ti_wireupdate (ti_clk, ti_reset, bus slave modport, busy, err_addr, err_timeout; OK_WIRESEQ_TIMEOUT_EN adds mid-batch stall timeout)
module ok_wirein_sched
  import ok_wirein_sched_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_LO = 8'h00,
  parameter logic [ADDR_W-1:0] ADDR_HI = 8'h1F,
  parameter int                TIMEOUT = 16
) (
  input  logic             ti_clk,
  input  logic             ti_reset,
  ok_wirein_sched_if.slave bus,
  output logic             busy,
  output logic             err_addr,
  output logic             err_timeout
);
  state_t state;
  cmd_t   cmd;
  logic   any, owner, acc, ok;
  ok_rr_arb2 u_arb (
    .clk  (ti_clk),
    .rst  (ti_reset),
    .req  ({bus.req1_valid, bus.req0_valid}),
    .take (state == IDLE && any),
    .done (state == GAP),
    .any  (any),
    .owner(owner)
  );
  assign cmd = owner ? cmd_t'{bus.req1_addr, bus.req1_data, bus.req1_last}
                     : cmd_t'{bus.req0_addr, bus.req0_data, bus.req0_last};
  assign acc = state == XFER && (owner ? bus.req1_valid : bus.req0_valid);
  assign ok  = in_range(cmd.addr, ADDR_LO, ADDR_HI);
  assign bus.req0_ready = state == XFER && !owner && bus.req0_valid;
  assign bus.req1_ready = state == XFER && owner && bus.req1_valid;
  assign busy = state != IDLE;
`ifdef OK_WIRESEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`else
  assign err_timeout = 1'b0;
`endif
  always_ff @(posedge ti_clk) begin
    if (ti_reset) begin
      state             <= IDLE;
      bus.ti_write      <= 1'b0;
      bus.ti_addr       <= '0;
      bus.ti_datain     <= '0;
      bus.ti_wireupdate <= 1'b0;
      err_addr          <= 1'b0;
`ifdef OK_WIRESEQ_TIMEOUT_EN
      err_timeout       <= 1'b0;
      cnt               <= '0;
`endif
    end else begin
      bus.ti_write      <= acc && ok;
      bus.ti_wireupdate <= state == UPDATE;
      if (acc && ok) begin
        bus.ti_addr   <= cmd.addr;
        bus.ti_datain <= cmd.data;
      end
      if (acc && !ok) err_addr <= 1'b1;
      case (state)
        IDLE:    if (any) state <= XFER;
        XFER: begin
          if (acc && cmd.last) state <= UPDATE;
`ifdef OK_WIRESEQ_TIMEOUT_EN
          if (acc) cnt <= '0;
          else if (cnt == CW'(TIMEOUT - 1)) begin
            state       <= UPDATE;
            err_timeout <= 1'b1;
            cnt         <= '0;
          end else cnt <= cnt + 1'b1;
`endif
        end
        UPDATE:  state <= GAP;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ok_wirein_sched.sv
// tb_ok_wirein_sched: cycle table of requester inputs vs expected ready/ti_*/busy/err outputs, plus a mid-batch stall sequence
module tb_ok_wirein_sched;
  typedef struct {
    logic rst;
    logic v0; logic [7:0] a0; logic [31:0] d0; logic l0;
    logic v1; logic [7:0] a1; logic [31:0] d1; logic l1;
    logic r0; logic r1; logic wr; logic [7:0] ta; logic [31:0] td; logic up; logic bz; logic ea;
  } vec_t;
  localparam logic H = 1'b1, L = 1'b0;
  logic ti_clk = 1'b0, ti_reset = 1'b1;
  logic busy, err_addr, err_timeout;
  int n_chk = 0, n_fail = 0;
  vec_t tbl [$];
  ok_wirein_sched_if bus ();
  ok_wirein_sched dut (
    .ti_clk     (ti_clk),
    .ti_reset   (ti_reset),
    .bus        (bus),
    .busy       (busy),
    .err_addr   (err_addr),
    .err_timeout(err_timeout)
  );
  always #5 ti_clk = ~ti_clk;
  task automatic chk(input string n, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h want %h", n, row, act, exp);
    end
  endtask
  task automatic add(input logic rst, v0, input logic [7:0] a0, input logic [31:0] d0, input logic l0,
                     input logic v1, input logic [7:0] a1, input logic [31:0] d1, input logic l1,
                     input logic r0, r1, wr, input logic [7:0] ta, input logic [31:0] td,
                     input logic up, bz, ea);
    tbl.push_back(vec_t'{rst, v0, a0, d0, l0, v1, a1, d1, l1, r0, r1, wr, ta, td, up, bz, ea});
  endtask
  initial begin
    int upd_at, n_upd;
    bus.req0_valid = 1'b0; bus.req0_addr = 8'h00; bus.req0_data = 32'h0; bus.req0_last = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_addr = 8'h00; bus.req1_data = 32'h0; bus.req1_last = 1'b0;
    add(H, L,8'h00,32'h0,L,  L,8'h00,32'h0,L,  L,L,L,8'h00,32'h0,L,L,L);
    add(L, H,8'h01,32'hA,L,  L,8'h00,32'h0,L,  L,L,L,8'h00,32'h0,L,L,L);
    add(L, H,8'h01,32'hA,L,  L,8'h00,32'h0,L,  H,L,L,8'h00,32'h0,L,H,L);
    add(L, H,8'h02,32'hB,L,  L,8'h00,32'h0,L,  H,L,H,8'h01,32'hA,L,H,L);
    add(L, H,8'h03,32'hC,H,  L,8'h00,32'h0,L,  H,L,H,8'h02,32'hB,L,H,L);
    add(L, L,8'h03,32'hC,H,  L,8'h00,32'h0,L,  L,L,H,8'h03,32'hC,L,H,L);
    add(L, L,8'h03,32'hC,H,  L,8'h00,32'h0,L,  L,L,L,8'h03,32'hC,H,H,L);
    add(L, L,8'h03,32'hC,H,  L,8'h00,32'h0,L,  L,L,L,8'h03,32'hC,L,L,L);
    add(L, H,8'h05,32'h55,H, H,8'h06,32'h66,H, L,L,L,8'h03,32'hC,L,L,L);
    add(L, H,8'h05,32'h55,H, H,8'h06,32'h66,H, L,H,L,8'h03,32'hC,L,H,L);
    add(L, H,8'h05,32'h55,H, H,8'h06,32'h66,H, L,L,H,8'h06,32'h66,L,H,L);
    add(L, H,8'h05,32'h55,H, H,8'h06,32'h66,H, L,L,L,8'h06,32'h66,H,H,L);
    add(L, H,8'h05,32'h55,H, H,8'h06,32'h66,H, L,L,L,8'h06,32'h66,L,L,L);
    add(L, H,8'h05,32'h55,H, H,8'h06,32'h66,H, H,L,L,8'h06,32'h66,L,H,L);
    add(L, L,8'h05,32'h55,H, L,8'h06,32'h66,H, L,L,H,8'h05,32'h55,L,H,L);
    add(L, L,8'h05,32'h55,H, L,8'h06,32'h66,H, L,L,L,8'h05,32'h55,H,H,L);
    add(L, L,8'h05,32'h55,H, H,8'h07,32'h77,L, L,L,L,8'h05,32'h55,L,L,L);
    add(L, H,8'h09,32'h99,H, H,8'h07,32'h77,L, L,H,L,8'h05,32'h55,L,H,L);
    add(L, H,8'h09,32'h99,H, H,8'h08,32'h88,H, L,H,H,8'h07,32'h77,L,H,L);
    add(L, H,8'h09,32'h99,H, L,8'h08,32'h88,H, L,L,H,8'h08,32'h88,L,H,L);
    add(L, H,8'h09,32'h99,H, L,8'h08,32'h88,H, L,L,L,8'h08,32'h88,H,H,L);
    add(L, H,8'h09,32'h99,H, L,8'h08,32'h88,H, L,L,L,8'h08,32'h88,L,L,L);
    add(L, H,8'h09,32'h99,H, L,8'h08,32'h88,H, H,L,L,8'h08,32'h88,L,H,L);
    add(L, L,8'h09,32'h99,H, L,8'h08,32'h88,H, L,L,H,8'h09,32'h99,L,H,L);
    add(L, L,8'h09,32'h99,H, L,8'h08,32'h88,H, L,L,L,8'h09,32'h99,H,H,L);
    add(L, H,8'h40,32'hEE,H, L,8'h08,32'h88,H, L,L,L,8'h09,32'h99,L,L,L);
    add(L, H,8'h40,32'hEE,H, L,8'h08,32'h88,H, H,L,L,8'h09,32'h99,L,H,L);
    add(L, L,8'h40,32'hEE,H, L,8'h08,32'h88,H, L,L,L,8'h09,32'h99,L,H,H);
    add(L, L,8'h40,32'hEE,H, L,8'h08,32'h88,H, L,L,L,8'h09,32'h99,H,H,H);
    add(L, H,8'h01,32'h11,L, L,8'h08,32'h88,H, L,L,L,8'h09,32'h99,L,L,H);
    add(L, H,8'h01,32'h11,L, L,8'h08,32'h88,H, H,L,L,8'h09,32'h99,L,H,H);
    add(H, H,8'h02,32'h22,L, L,8'h08,32'h88,H, H,L,H,8'h01,32'h11,L,H,H);
    add(L, H,8'h03,32'h33,H, H,8'h0A,32'hAA,H, L,L,L,8'h00,32'h0,L,L,L);
    add(L, H,8'h03,32'h33,H, H,8'h0A,32'hAA,H, H,L,L,8'h00,32'h0,L,H,L);
    add(L, L,8'h03,32'h33,H, H,8'h0A,32'hAA,H, L,L,H,8'h03,32'h33,L,H,L);
    add(L, L,8'h03,32'h33,H, H,8'h0A,32'hAA,H, L,L,L,8'h03,32'h33,H,H,L);
    add(L, L,8'h03,32'h33,H, H,8'h0A,32'hAA,H, L,L,L,8'h03,32'h33,L,L,L);
    add(L, L,8'h03,32'h33,H, H,8'h0A,32'hAA,H, L,H,L,8'h03,32'h33,L,H,L);
    add(L, L,8'h03,32'h33,H, L,8'h0A,32'hAA,H, L,L,H,8'h0A,32'hAA,L,H,L);
    add(L, L,8'h03,32'h33,H, L,8'h0A,32'hAA,H, L,L,L,8'h0A,32'hAA,H,H,L);
    add(L, L,8'h03,32'h33,H, L,8'h0A,32'hAA,H, L,L,L,8'h0A,32'hAA,L,L,L);
    foreach (tbl[i]) begin
      @(negedge ti_clk);
      ti_reset = tbl[i].rst;
      bus.req0_valid = tbl[i].v0; bus.req0_addr = tbl[i].a0; bus.req0_data = tbl[i].d0; bus.req0_last = tbl[i].l0;
      bus.req1_valid = tbl[i].v1; bus.req1_addr = tbl[i].a1; bus.req1_data = tbl[i].d1; bus.req1_last = tbl[i].l1;
      #1;
      chk("req0_ready", i, 32'(bus.req0_ready), 32'(tbl[i].r0));
      chk("req1_ready", i, 32'(bus.req1_ready), 32'(tbl[i].r1));
      chk("ti_write", i, 32'(bus.ti_write), 32'(tbl[i].wr));
      chk("ti_addr", i, 32'(bus.ti_addr), 32'(tbl[i].ta));
      chk("ti_datain", i, bus.ti_datain, tbl[i].td);
      chk("ti_wireupdate", i, 32'(bus.ti_wireupdate), 32'(tbl[i].up));
      chk("busy", i, 32'(busy), 32'(tbl[i].bz));
      chk("err_addr", i, 32'(err_addr), 32'(tbl[i].ea));
      chk("err_timeout", i, 32'(err_timeout), 32'(0));
    end
    @(negedge ti_clk);
    bus.req0_valid = 1'b1; bus.req0_addr = 8'h10; bus.req0_data = 32'h1234; bus.req0_last = 1'b0;
    @(negedge ti_clk); #1;
    chk("stall_ready", 100, 32'(bus.req0_ready), 32'(1));
    @(negedge ti_clk);
    bus.req0_valid = 1'b0; #1;
    chk("stall_write", 101, 32'(bus.ti_write), 32'(1));
    chk("stall_addr", 101, 32'(bus.ti_addr), 32'(8'h10));
    upd_at = 0; n_upd = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge ti_clk); #1;
      if (bus.ti_wireupdate) begin
        n_upd++;
        if (upd_at == 0) upd_at = i;
      end
    end
`ifdef OK_WIRESEQ_TIMEOUT_EN
    chk("tmo_updates", 102, 32'(n_upd), 32'(1));
    chk("tmo_update_cycle", 102, 32'(upd_at), 32'(17));
    chk("tmo_err_timeout", 102, 32'(err_timeout), 32'(1));
    chk("tmo_busy", 102, 32'(busy), 32'(0));
`else
    chk("stall_updates", 102, 32'(n_upd), 32'(0));
    chk("stall_busy", 102, 32'(busy), 32'(1));
    chk("stall_err_timeout", 102, 32'(err_timeout), 32'(0));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
